// File: rtl/lfsr_decrypt_if.sv
// Request/acknowledge handshake, data-memory port and result flags of the LFSR decryptor.
// master is the decryptor side; slave is the requester/memory side.
interface lfsr_decrypt_if;
  logic       req;
  logic       ack;
  logic [7:0] mem_addr;
  logic       mem_rd_en;
  logic [7:0] mem_rdata;
  logic       mem_wr_en;
  logic [7:0] mem_wdata;
  logic [3:0] pat_idx;
  logic       err;

  modport master (
    input  req, mem_rdata,
    output ack, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, pat_idx, err
  );

  modport slave (
    output req, mem_rdata,
    input  ack, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, pat_idx, err
  );
endinterface

// File: rtl/lfsr_decrypt.sv
// Decrypts mem[64..127] into mem[0..63]: identifies the LFSR tap pattern from the
// first ten ciphertext bytes, strips the all-zero preamble and writes the message.
//
// state  | meaning
// IDLE   | waiting for req
// LOAD   | 64 pipelined reads of mem[64..127] into the buffer (65 cycles)
// SEARCH | trying tap candidates 0..8 against buf[1..9]
// WRITE  | skipping the preamble, then 64 ascending writes to mem[0..63]
// DONE   | ack high until req drops; pat_idx/err valid
module lfsr_decrypt (
  input logic            clk,
  input logic            init_n,
  lfsr_decrypt_if.master bus
);

  typedef enum logic [2:0] {IDLE, LOAD, SEARCH, WRITE, DONE} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [6:0] cbuf [64];
  logic [6:0] cnt;
  logic [5:0] cap_idx;
  logic [3:0] cand;
  logic [6:0] lfsr;
  logic [6:0] lfsr_nxt;
  logic [6:0] pos;
  logic [6:0] wcnt;
  logic       writing;
  logic       hit;
  logic [6:0] plain;

  function automatic logic [6:0] tap_of(input logic [3:0] p);
    case (p)
      4'd0:    tap_of = 7'h60;
      4'd1:    tap_of = 7'h48;
      4'd2:    tap_of = 7'h78;
      4'd3:    tap_of = 7'h72;
      4'd4:    tap_of = 7'h6A;
      4'd5:    tap_of = 7'h69;
      4'd6:    tap_of = 7'h5C;
      4'd7:    tap_of = 7'h7E;
      default: tap_of = 7'h7B;
    endcase
  endfunction

  assign lfsr_nxt = {lfsr[5:0], ^(lfsr & tap_of(cand))};
  assign hit      = (lfsr_nxt == cbuf[cnt[5:0]]);
  assign plain    = cbuf[pos[5:0]] ^ lfsr;
  // cnt runs 1..64 while captures land; cnt==64 wraps to index 63
  assign cap_idx  = cnt[5:0] - 6'd1;
  assign bus.ack  = (state == DONE);

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.req) state_nxt = LOAD;
      LOAD:    if (cnt == 7'd64) state_nxt = (cbuf[0] == 7'd0) ? DONE : SEARCH;
      SEARCH: begin
        if (hit && cnt == 7'd9)        state_nxt = WRITE;
        else if (!hit && cand == 4'd8) state_nxt = DONE;
      end
      WRITE:   if (wcnt == 7'd64) state_nxt = DONE;
      DONE:    if (!bus.req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == LOAD && cnt != 7'd0) cbuf[cap_idx] <= bus.mem_rdata[6:0];
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      bus.mem_rd_en <= 1'b0;
      bus.mem_wr_en <= 1'b0;
      bus.mem_addr  <= 8'd0;
      bus.mem_wdata <= 8'd0;
      bus.err       <= 1'b0;
      bus.pat_idx   <= 4'hF;
      cnt           <= 7'd0;
      cand          <= 4'd0;
      lfsr          <= 7'd0;
      pos           <= 7'd0;
      wcnt          <= 7'd0;
      writing       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.req) begin
          bus.mem_rd_en <= 1'b1;
          bus.mem_addr  <= 8'd64;
          bus.pat_idx   <= 4'hF;
          bus.err       <= 1'b0;
          cnt           <= 7'd0;
        end
        LOAD: begin
          cnt           <= cnt + 7'd1;
          bus.mem_rd_en <= (cnt < 7'd63);
          if (cnt < 7'd63) bus.mem_addr <= 8'd65 + {1'b0, cnt};
          if (cnt == 7'd64) begin
            if (cbuf[0] == 7'd0) bus.err <= 1'b1;
            cand <= 4'd0;
            cnt  <= 7'd1;
            lfsr <= cbuf[0];
          end
        end
        SEARCH: begin
          if (hit) begin
            if (cnt == 7'd9) begin
              bus.pat_idx <= cand;
              lfsr        <= cbuf[0];
              pos         <= 7'd0;
              wcnt        <= 7'd0;
              writing     <= 1'b0;
            end else begin
              lfsr <= lfsr_nxt;
              cnt  <= cnt + 7'd1;
            end
          end else if (cand == 4'd8) begin
            bus.err <= 1'b1;
          end else begin
            cand <= cand + 4'd1;
            lfsr <= cbuf[0];
            cnt  <= 7'd1;
          end
        end
        WRITE: begin
          if (wcnt == 7'd64) begin
            bus.mem_wr_en <= 1'b0;
          end else if (!writing && !pos[6] && plain == 7'd0) begin
            pos  <= pos + 7'd1;
            lfsr <= lfsr_nxt;
          end else begin
            // pos saturates at 64: everything past the message end is padding
            writing       <= 1'b1;
            bus.mem_wr_en <= 1'b1;
            bus.mem_addr  <= {1'b0, wcnt};
            bus.mem_wdata <= pos[6] ? 8'd0 : {1'b0, plain};
            wcnt          <= wcnt + 7'd1;
            if (!pos[6]) begin
              pos  <= pos + 7'd1;
              lfsr <= lfsr_nxt;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_decrypt.sv
// Self-checking bench for lfsr_decrypt: table of randomized runs against a reference
// model, plus hand-written reset, busy-toggle, hold-ack and mid-write reset sequences.
module tb_lfsr_decrypt;

  logic clk = 1'b0;
  logic init_n = 1'b0;
  always #5 clk = ~clk;

  lfsr_decrypt_if bus ();
  lfsr_decrypt dut (.clk(clk), .init_n(init_n), .bus(bus.master));

  typedef struct {
    int tap_i;
    int seed;
    int pre;
    int mlen;
    bit corrupt;
    bit zero;
    bit exp_err;
  } vec_t;

  logic [6:0] taps [9] = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B};
  string      msg = "Mr. Watson, come here. I want to see you.";

  logic [7:0] mem   [256];
  logic [7:0] stage [256];
  logic [7:0] cip   [64];
  logic [7:0] exp_img [64];
  int         exp_pat;
  bit         exp_err;
  int         load_gen = 0, load_seen = 0;
  int         wr_cnt = 0, rd_cnt = 0, viol_cnt = 0;
  int         n_chk = 0, n_err = 0;
  vec_t       vecs [9];

  always @(posedge clk) begin
    if (load_gen != load_seen) begin
      for (int i = 0; i < 256; i++) mem[i] = stage[i];
      load_seen = load_gen;
    end
    if (bus.mem_wr_en && bus.mem_addr >= 8'd64) viol_cnt++;
    if (bus.mem_wr_en && bus.mem_rd_en) viol_cnt++;
    if (bus.ack && (bus.mem_wr_en || bus.mem_rd_en)) viol_cnt++;
    if (bus.mem_wr_en) begin
      mem[bus.mem_addr] = bus.mem_wdata;
      wr_cnt++;
    end
    if (bus.mem_rd_en) begin
      bus.mem_rdata <= mem[bus.mem_addr];
      rd_cnt++;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [6:0] lfsr_step(input logic [6:0] s, input logic [6:0] t);
    return {s[5:0], ^(s & t)};
  endfunction

  task automatic make_cipher(input int tap_i, input int seed, input int pre, input int mlen,
                             input bit corrupt, input bit zero, input bit use_msg);
    logic [6:0] s, pl;
    logic [7:0] ch;
    int         len;
    s   = 7'(seed);
    len = use_msg ? msg.len() : mlen;
    for (int k = 0; k < 64; k++) begin
      if (k < pre || k >= pre + len) pl = 7'd0;
      else if (use_msg) begin
        ch = msg[k - pre] - 8'h20;
        pl = ch[6:0];
      end else if (k == pre) pl = 7'($urandom_range(1, 8'h5E));
      else pl = 7'($urandom_range(0, 8'h5E));
      cip[k] = zero ? 8'd0 : {1'b0, pl ^ s};
      s = lfsr_step(s, taps[tap_i]);
    end
    if (corrupt) cip[3] = cip[3] ^ 8'h2A;
  endtask

  // Reference: search taps over the whole first-ten window, decrypt, strip preamble.
  task automatic ref_model();
    logic [6:0] seq [10];
    logic [7:0] pl [64];
    logic [6:0] s;
    int         l;
    exp_pat = 15;
    exp_err = 1'b1;
    for (int a = 0; a < 64; a++) exp_img[a] = stage[a];
    if (cip[0][6:0] != 7'd0) begin
      for (int p = 0; p < 9 && exp_pat == 15; p++) begin
        seq[0] = cip[0][6:0];
        for (int k = 1; k < 10; k++) seq[k] = lfsr_step(seq[k-1], taps[p]);
        exp_pat = p;
        for (int k = 1; k < 10; k++) if (seq[k] != cip[k][6:0]) exp_pat = 15;
      end
    end
    if (exp_pat != 15) begin
      exp_err = 1'b0;
      s = cip[0][6:0];
      for (int k = 0; k < 64; k++) begin
        pl[k] = {1'b0, cip[k][6:0] ^ s};
        s = lfsr_step(s, taps[exp_pat]);
      end
      l = 0;
      while (l < 64 && pl[l] == 8'd0) l++;
      for (int a = 0; a < 64; a++) exp_img[a] = (a + l < 64) ? pl[a + l] : 8'd0;
    end
  endtask

  task automatic stage_mem();
    for (int i = 0; i < 64; i++) begin
      stage[i]      = 8'($urandom_range(0, 255));
      stage[64 + i] = cip[i];
    end
    for (int i = 128; i < 256; i++) stage[i] = 8'h00;
    load_gen++;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic run_case(input string tag, input bit toggle, input bit hold, input bit check_fast);
    int w0, r0, v0, cyc, nmis, r_hold;
    bit held;
    stage_mem();
    ref_model();
    w0 = wr_cnt; r0 = rd_cnt; v0 = viol_cnt;
    bus.req = 1'b1;
    cyc = 0;
    while (!bus.ack && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (toggle && cyc == 5)  bus.req = 1'b0;
      if (toggle && cyc == 40) bus.req = 1'b1;
    end
    chk({tag, " ack_seen"}, int'(bus.ack), 1);
    if (check_fast) chk({tag, " ack_latency_le_70"}, int'(cyc <= 70), 1);
    chk({tag, " pat_idx"}, int'(bus.pat_idx), exp_pat);
    chk({tag, " err"}, int'(bus.err), int'(exp_err));
    chk({tag, " writes"}, wr_cnt - w0, exp_err ? 0 : 64);
    chk({tag, " reads"}, rd_cnt - r0, 64);
    nmis = 0;
    for (int a = 0; a < 64; a++) if (mem[a] !== exp_img[a]) nmis++;
    chk({tag, " mem_image_mismatches"}, nmis, 0);
    if (hold) begin
      held = 1'b1;
      r_hold = rd_cnt;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (bus.ack !== 1'b1) held = 1'b0;
      end
      chk({tag, " ack_held_10"}, int'(held), 1);
      chk({tag, " no_rerun_while_held"}, rd_cnt - r_hold, 0);
    end
    bus.req = 1'b0;
    @(negedge clk);
    chk({tag, " ack_drop"}, int'(bus.ack), 0);
    chk({tag, " bus_violations"}, viol_cnt - v0, 0);
    @(negedge clk);
  endtask

  initial begin
    int w0, cyc;
    bus.req = 1'b0;
    vecs[0] = '{8, -1, 26, 28, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{0, -1,  0,  0, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{4, -1, 10, 54, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{3, -1, 10, 54, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{5, -1, 64,  0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1, -1, 12, 30, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{2, -1, 15, 40, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{6, -1, 11, 20, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{7, -1, 20, 44, 1'b0, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst ack", int'(bus.ack), 0);
    chk("rst rd_en", int'(bus.mem_rd_en), 0);
    chk("rst wr_en", int'(bus.mem_wr_en), 0);
    chk("rst addr", int'(bus.mem_addr), 0);
    chk("rst wdata", int'(bus.mem_wdata), 0);
    chk("rst err", int'(bus.err), 0);
    chk("rst pat_idx", int'(bus.pat_idx), 15);
    init_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle no reads", rd_cnt, 0);

    make_cipher(0, 1, 10, 0, 1'b0, 1'b0, 1'b1);
    run_case("watson", 1'b0, 1'b0, 1'b0);
    chk("watson pat0", int'(bus.pat_idx), 0);
    chk("watson mem0", int'(mem[0]), 8'h2D);

    for (int v = 0; v < 9; v++) begin
      make_cipher(vecs[v].tap_i, (vecs[v].seed < 0) ? int'($urandom_range(1, 127)) : vecs[v].seed,
                  vecs[v].pre, vecs[v].mlen, vecs[v].corrupt, vecs[v].zero, 1'b0);
      run_case($sformatf("vec%0d", v), 1'b0, 1'b0, vecs[v].zero);
      chk($sformatf("vec%0d err_table", v), int'(exp_err), int'(vecs[v].exp_err));
    end

    make_cipher(4, int'($urandom_range(1, 127)), 13, 35, 1'b0, 1'b0, 1'b0);
    run_case("busy_toggle", 1'b1, 1'b0, 1'b0);
    make_cipher(8, int'($urandom_range(1, 127)), 10, 30, 1'b0, 1'b0, 1'b0);
    run_case("hold_req", 1'b0, 1'b1, 1'b0);

    make_cipher(2, int'($urandom_range(1, 127)), 10, 50, 1'b0, 1'b0, 1'b0);
    stage_mem();
    w0 = wr_cnt;
    bus.req = 1'b1;
    cyc = 0;
    while ((wr_cnt - w0) < 20 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    chk("midwrite reached_20", int'((wr_cnt - w0) >= 20), 1);
    init_n = 1'b0;
    #1;
    chk("midwrite wr_en_off", int'(bus.mem_wr_en), 0);
    chk("midwrite rd_en_off", int'(bus.mem_rd_en), 0);
    chk("midwrite ack_off", int'(bus.ack), 0);
    w0 = wr_cnt;
    bus.req = 1'b0;
    repeat (3) @(negedge clk);
    chk("midwrite no_more_writes", wr_cnt - w0, 0);
    init_n = 1'b1;
    repeat (2) @(negedge clk);
    run_case("after_reset", 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/lfsr_decrypt.md
LFSR_DECRYPT -- requirements
Module: lfsr_decrypt

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port init_n, input, 1, reset; asynchronous, active-low.
REQ-003 SHALL have port req, input, 1, level request to start decryption.
REQ-004 SHALL have port ack, output, 1, run complete; held until req is low.
REQ-005 SHALL have port mem_addr, output, 8, data-memory byte address.
REQ-006 SHALL have port mem_rd_en, output, 1, read strobe; mem_rdata is valid one cycle after the strobe.
REQ-007 SHALL have port mem_rdata, input, 8, data-memory read data.
REQ-008 SHALL have port mem_wr_en, output, 1, write strobe; the write commits at the same edge.
REQ-009 SHALL have port mem_wdata, output, 8, data-memory write data.
REQ-010 SHALL have port pat_idx, output, 4, index 0-8 of the detected tap pattern; 4'hF if none.
REQ-011 SHALL have port err, output, 1, no valid pattern or zero seed found.

Function
REQ-012 SHALL decrypt the 64-byte ciphertext at mem[64..127], whose bit7 is always 0, into plaintext at mem[0..63], with space stored as 0x00.
REQ-013 SHALL use tap table [0]=60 [1]=48 [2]=78 [3]=72 [4]=6A [5]=69 [6]=5C [7]=7E [8]=7B (hex), hard-coded.
REQ-014 SHALL compute the LFSR next state as {s[5:0], ^(s[6:0] & tap[6:0])}, 7 bits wide.
REQ-015 SHALL have FSM states IDLE, LOAD, SEARCH, WRITE, DONE.
REQ-016 SHALL go IDLE->LOAD when req is high in IDLE.
REQ-017 In LOAD, SHALL read mem[64+i] for i=0..63 into a 64x7 internal buffer (bits [6:0]), one read per cycle, pipelined; LOAD lasts 65 cycles.
REQ-018 SHALL take seed = buf[0][6:0]; seed==0 SHALL go straight to DONE with err=1 and pat_idx=F.
REQ-019 In SEARCH, SHALL test candidates p=0..8 in order, advancing the LFSR from the seed one step per cycle and comparing buf[k] for k=1..9.
REQ-020 On a SEARCH mismatch, SHALL abort the candidate and restart at p+1 on the next cycle.
REQ-021 The first candidate matching all 9 SHALL win; SEARCH SHALL take at most 81 cycles.
REQ-022 If no candidate matches, SHALL go to DONE with err=1, pat_idx=F, and no memory writes.
REQ-023 In WRITE, SHALL compute plain[k] = {1'b0, buf[k] ^ lfsr[k]} for k=0..63, with lfsr[0]=seed.
REQ-024 SHALL count leading plain bytes equal to 0x00 (the preamble), L, which is at least 10.
REQ-025 SHALL write plain[L..63] to mem[0..63-L] and then 0x00 to mem[64-L..63]: exactly 64 writes, one per cycle, addresses ascending.
REQ-026 SHALL write no address at or above 64, ever.
REQ-027 SHALL write all 0x00 when every plain byte is 0x00 (L=64).
REQ-028 SHALL treat a plaintext byte equal to 0x00 after the first nonzero byte as message data, not preamble.
REQ-029 In DONE, SHALL hold ack=1 while req=1, go to IDLE when req=0, and drop ack in the cycle IDLE is entered.
REQ-030 SHALL hold pat_idx and err stable from DONE until the next LOAD entry, where both clear.
REQ-031 SHALL ignore req toggling while busy (LOAD, SEARCH, WRITE).
REQ-032 SHALL hold mem_rd_en and mem_wr_en mutually exclusive, and both 0 outside LOAD and WRITE.

Reset
REQ-033 On init_n low, SHALL immediately enter IDLE, whatever the current state.
REQ-034 On reset, SHALL clear ack, mem_rd_en, mem_wr_en, mem_addr, mem_wdata and err to 0, and set pat_idx to F.
REQ-035 A reset during WRITE SHALL abandon the remaining writes, with no further strobes.
REQ-036 The buffer contents are don't-care after reset.
REQ-037 After init_n rises, SHALL start no new run until req is sampled high in IDLE.

Verification
REQ-038 Tap 60, seed 01, "Mr. Watson..." with preamble 10 -> ciphertext[0..6] = 01 02 04 08 10 20 41; expect pat_idx=0, err=0, mem[0]=0x2D ('M'-0x20), mem[41..63]=0x00, ack high.
REQ-039 Tap 7B, random seed, preamble 26, 28-char message -> pat_idx=8, err=0, mem[0..27] = message-0x20, mem[28..63]=0x00, exactly 64 writes.
REQ-040 Ciphertext all 0x00 -> seed zero: err=1, pat_idx=F, no mem_wr_en, ack within 70 cycles of req.
REQ-041 Ciphertext random with byte3 corrupted, matching no pattern -> err=1, pat_idx=F, mem[0..63] unchanged.
REQ-042 Pulse init_n low mid-WRITE (after the 20th write) -> all strobes stop that cycle, ack=0; a new req yields a correct complete run.
REQ-043 Hold req high through DONE for 10 cycles -> ack stays 1 and no new run starts; req low -> ack 0 on the next cycle.
